iqmap_qpsk: RTL and testbench

- Transmit-side QPSK mapper. Accepts 32-bit words on a valid/ready handshake, serialises each word into 16 two-bit symbols (LSB pair first), and maps each symbol to signed 11-bit I/Q samples.
- Sits between the framing/packet logic and the DAC/modulator front end. Symbol order and sign convention are the inverse of the QPSK demap/collect chain.
- Also exports a raw 2-bit symbol tap for debug and loopback.

---
 rtl/qpsk_pkg.sv | 24 ++
 rtl/iqmap_qpsk_if.sv | 25 ++
 rtl/qpsk_map.sv | 19 +
 rtl/iqmap_qpsk.sv | 111 +++++++++++
 tb/tb_iqmap_qpsk.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK transmit mapper.
package qpsk_pkg;

    localparam int unsigned QPSK_AMP_DEFAULT   = 724;
    localparam int unsigned QPSK_SYMS_PER_WORD = 16;
    localparam int unsigned IQ_W               = 11;
    localparam int unsigned WORD_W             = 32;
    localparam int unsigned SYM_W              = 2;
    localparam int unsigned REM_W              = $clog2(QPSK_SYMS_PER_WORD);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef logic [SYM_W-1:0]       sym_t;
    typedef logic signed [IQ_W-1:0] iq_t;

    typedef struct packed {
        iq_t ar;
        iq_t ai;
    } iq_pair_t;

endpackage

// File: rtl/iqmap_qpsk_if.sv
// Word-in handshake plus I/Q sample output bundle of the QPSK mapper.
interface iqmap_qpsk_if;
    import qpsk_pkg::*;

    logic              valid_i;
    logic [WORD_W-1:0] data_i;
    logic              ready_o;
    logic              valid_o;
    iq_t               ar;
    iq_t               ai;
    logic              valid_raw;
    sym_t              raw;
    logic              busy;

    modport slave (
        input  valid_i, data_i,
        output ready_o, valid_o, ar, ai, valid_raw, raw, busy
    );

    modport master (
        output valid_i, data_i,
        input  ready_o, valid_o, ar, ai, valid_raw, raw, busy
    );

endinterface

// File: rtl/qpsk_map.sv
// Combinational QPSK constellation lookup: bit0 sets the I sign, bit1 the Q sign.
module qpsk_map
    import qpsk_pkg::*;
#(
    parameter int unsigned AMP = QPSK_AMP_DEFAULT
) (
    input  sym_t     sym_i,
    output iq_pair_t iq_o
);

    localparam iq_t POS = iq_t'(AMP);
    localparam iq_t NEG = -POS;

    always_comb begin
        iq_o.ar = sym_i[0] ? NEG : POS;
        iq_o.ai = sym_i[1] ? NEG : POS;
    end

endmodule

// File: rtl/iqmap_qpsk.sv
// QPSK transmit mapper: serialises 32-bit words LSB pair first into 16 symbols,
// each held for SYM_PERIOD clocks as registered signed I/Q samples.
module iqmap_qpsk
    import qpsk_pkg::*;
#(
    parameter int unsigned AMP        = QPSK_AMP_DEFAULT,
    parameter int unsigned SYM_PERIOD = 1
) (
    input  logic            CLK,
    input  logic            RST,
    iqmap_qpsk_if.slave     bus
);

    localparam int unsigned SREG_W = WORD_W - SYM_W;
    localparam int unsigned PCNT_W = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(SYM_PERIOD - 1);
    localparam logic [REM_W-1:0]  REM_LOAD  = REM_W'(QPSK_SYMS_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [SREG_W-1:0] sreg_q,  sreg_d;
    logic [REM_W-1:0]  rem_q,   rem_d;
    logic [PCNT_W-1:0] pcnt_q,  pcnt_d;
    logic              valid_q, valid_d;
    iq_pair_t          iq_q,    iq_d;
    sym_t              raw_q,   raw_d;

    logic              ready_c;
    logic              accept_c;
    sym_t              sym_sel_c;
    iq_pair_t          map_iq_c;

    // Ready on idle, or in the final cycle of the last symbol so words stream gaplessly.
    always_comb begin
        ready_c   = (state_q == IDLE) ||
                    ((state_q == SEND) && (rem_q == '0) && (pcnt_q == '0));
        accept_c  = bus.valid_i && ready_c;
        sym_sel_c = accept_c ? bus.data_i[SYM_W-1:0] : sreg_q[SYM_W-1:0];
    end

    qpsk_map #(
        .AMP (AMP)
    ) u_map (
        .sym_i (sym_sel_c),
        .iq_o  (map_iq_c)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            rem_q   <= '0;
            pcnt_q  <= '0;
            valid_q <= 1'b0;
            iq_q    <= '0;
            raw_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            rem_q   <= rem_d;
            pcnt_q  <= pcnt_d;
            valid_q <= valid_d;
            iq_q    <= iq_d;
            raw_q   <= raw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        rem_d   = rem_q;
        pcnt_d  = pcnt_q;
        valid_d = 1'b0;
        iq_d    = iq_q;
        raw_d   = raw_q;

        if (accept_c) begin
            state_d = SEND;
            sreg_d  = bus.data_i[WORD_W-1:SYM_W];
            rem_d   = REM_LOAD;
            pcnt_d  = PCNT_LOAD;
            valid_d = 1'b1;
            iq_d    = map_iq_c;
            raw_d   = sym_sel_c;
        end else if (state_q == SEND) begin
            if (pcnt_q != '0) begin
                pcnt_d = pcnt_q - PCNT_W'(1);
            end else if (rem_q != '0) begin
                sreg_d  = {{SYM_W{1'b0}}, sreg_q[SREG_W-1:SYM_W]};
                rem_d   = rem_q - REM_W'(1);
                pcnt_d  = PCNT_LOAD;
                valid_d = 1'b1;
                iq_d    = map_iq_c;
                raw_d   = sym_sel_c;
            end else begin
                // Last symbol done with no follow-on word: drop the carrier.
                state_d = IDLE;
                iq_d    = '0;
                raw_d   = '0;
            end
        end
    end

    assign bus.ready_o   = ready_c;
    assign bus.valid_o   = valid_q;
    assign bus.valid_raw = valid_q;
    assign bus.ar        = iq_q.ar;
    assign bus.ai        = iq_q.ai;
    assign bus.raw       = raw_q;
    assign bus.busy      = (state_q == SEND);

endmodule

// File: tb/tb_iqmap_qpsk.sv
// Directed self-checking bench for iqmap_qpsk at SYM_PERIOD 1 and 4.
module tb_iqmap_qpsk;
    import qpsk_pkg::*;

    localparam int AMP = 724;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    iqmap_qpsk_if a_if ();
    iqmap_qpsk_if b_if ();

    iqmap_qpsk #(.AMP(AMP), .SYM_PERIOD(1)) u_dut_p1 (
        .CLK (clk),
        .RST (rst_n),
        .bus (a_if.slave)
    );

    iqmap_qpsk #(.AMP(AMP), .SYM_PERIOD(4)) u_dut_p4 (
        .CLK (clk),
        .RST (rst_n),
        .bus (b_if.slave)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_i(input logic [1:0] s);
        return s[0] ? -AMP : AMP;
    endfunction

    function automatic int exp_q(input logic [1:0] s);
        return s[1] ? -AMP : AMP;
    endfunction

    task automatic check_idle_a(input string tag);
        check({tag, ".valid"}, a_if.valid_o, 0);
        check({tag, ".vraw"},  a_if.valid_raw, 0);
        check({tag, ".ar"},    a_if.ar, 0);
        check({tag, ".ai"},    a_if.ai, 0);
        check({tag, ".raw"},   a_if.raw, 0);
        check({tag, ".busy"},  a_if.busy, 0);
        check({tag, ".ready"}, a_if.ready_o, 1);
    endtask

    // Sends one word on the SYM_PERIOD=1 instance; optionally scrambles the inputs while busy.
    task automatic stream_a(input string tag, input logic [31:0] w, input bit noise);
        logic [1:0] s;
        @(negedge clk);
        a_if.valid_i = 1'b1;
        a_if.data_i  = w;
        check({tag, ".rdy0"}, a_if.ready_o, 1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            s = w[2*k +: 2];
            check($sformatf("%s.s%0d.valid", tag, k), a_if.valid_o, 1);
            check($sformatf("%s.s%0d.vraw", tag, k),  a_if.valid_raw, 1);
            check($sformatf("%s.s%0d.raw", tag, k),   a_if.raw, 32'(s));
            check($sformatf("%s.s%0d.ar", tag, k),    a_if.ar, exp_i(s));
            check($sformatf("%s.s%0d.ai", tag, k),    a_if.ai, exp_q(s));
            check($sformatf("%s.s%0d.busy", tag, k),  a_if.busy, 1);
            check($sformatf("%s.s%0d.ready", tag, k), a_if.ready_o, (k == 15) ? 1 : 0);
            if (noise && k != 15) begin
                a_if.valid_i = 1'($urandom_range(0, 1));
                a_if.data_i  = $urandom;
            end else begin
                a_if.valid_i = 1'b0;
            end
        end
        @(negedge clk);
        check_idle_a({tag, ".end"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [1:0]  s;
        logic [31:0] w;
        logic [1:0]  seq1b [4];
        seq1b = '{2'b11, 2'b10, 2'b01, 2'b00};

        a_if.valid_i = 1'b0;
        a_if.data_i  = '0;
        b_if.valid_i = 1'b0;
        b_if.data_i  = '0;

        repeat (2) @(negedge clk);
        check_idle_a("rst");
        check("rst.b.valid", b_if.valid_o, 0);
        check("rst.b.ar",    b_if.ar, 0);
        check("rst.b.busy",  b_if.busy, 0);
        rst_n = 1'b1;

        stream_a("zero", 32'h0000_0000, 1'b0);
        stream_a("w1b",  32'h1B1B_1B1B, 1'b0);

        // Hand table for 0x1B1B1B1B: raw 11,10,01,00 repeating.
        @(negedge clk);
        a_if.valid_i = 1'b1;
        a_if.data_i  = 32'h1B1B_1B1B;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            a_if.valid_i = 1'b0;
            check($sformatf("tbl.s%0d.raw", k), a_if.raw, 32'(seq1b[k % 4]));
        end
        @(negedge clk);
        check_idle_a("tbl.end");

        // Back-to-back: all-ones then all-zeros with valid held.
        @(negedge clk);
        a_if.valid_i = 1'b1;
        a_if.data_i  = 32'hFFFF_FFFF;
        check("b2b.rdy0", a_if.ready_o, 1);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            check($sformatf("b2b.s%0d.valid", k), a_if.valid_o, 1);
            check($sformatf("b2b.s%0d.ar", k), a_if.ar, (k < 16) ? -AMP : AMP);
            check($sformatf("b2b.s%0d.ai", k), a_if.ai, (k < 16) ? -AMP : AMP);
            check($sformatf("b2b.s%0d.ready", k), a_if.ready_o,
                  (k == 15 || k == 31) ? 1 : 0);
            if (k == 0)  a_if.data_i  = 32'h0000_0000;
            if (k == 16) a_if.valid_i = 1'b0;
        end
        @(negedge clk);
        check_idle_a("b2b.end");

        // SYM_PERIOD=4: each symbol 10 held four clocks.
        @(negedge clk);
        b_if.valid_i = 1'b1;
        b_if.data_i  = 32'hAAAA_AAAA;
        check("p4.rdy0", b_if.ready_o, 1);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            check($sformatf("p4.c%0d.valid", c), b_if.valid_o, (c % 4 == 0) ? 1 : 0);
            check($sformatf("p4.c%0d.ar", c),    b_if.ar, AMP);
            check($sformatf("p4.c%0d.ai", c),    b_if.ai, -AMP);
            check($sformatf("p4.c%0d.raw", c),   b_if.raw, 2);
            check($sformatf("p4.c%0d.busy", c),  b_if.busy, 1);
            check($sformatf("p4.c%0d.ready", c), b_if.ready_o, (c == 63) ? 1 : 0);
            b_if.valid_i = 1'b0;
        end
        @(negedge clk);
        check("p4.end.busy",  b_if.busy, 0);
        check("p4.end.ar",    b_if.ar, 0);
        check("p4.end.ai",    b_if.ai, 0);
        check("p4.end.valid", b_if.valid_o, 0);
        check("p4.end.ready", b_if.ready_o, 1);

        // Async reset after symbol 5 of a word.
        w = 32'h9C6E_1B27;
        @(negedge clk);
        a_if.valid_i = 1'b1;
        a_if.data_i  = w;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a_if.valid_i = 1'b0;
            s = w[2*k +: 2];
            check($sformatf("mid.s%0d.raw", k), a_if.raw, 32'(s));
            check($sformatf("mid.s%0d.ar", k),  a_if.ar, exp_i(s));
        end
        #2 rst_n = 1'b0;
        #1 check_idle_a("mid.rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_a("mid.post");
        stream_a("after", 32'h0000_00E4, 1'b0);

        // Inputs scrambled while busy must not disturb the accepted word.
        stream_a("noise", 32'h0F0F_55AA, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
